// File: rtl/or_nor_checker.sv
// rtl/or_nor_checker.sv - self-test driver and checker for a key-selectable OR/NOR gate
module or_nor_checker #(
   parameter int SETTLE = 1,
   parameter int ERR_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             r_in,
   output logic             x_out,
   output logic             y_out,
   output logic             key_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       fail_vec
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0]       CNT_INIT = 4'(SETTLE - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [7:0]       fail_q, fail_d;
   logic             expected;
   logic             mismatch;

   // The vector index is itself the registered {key,x,y} drive, so the gate
   // inputs change only on clock edges and hold 111 once the run is over.
   assign key_out   = idx_q[2];
   assign x_out     = idx_q[1];
   assign y_out     = idx_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

   // Reference gate value for the current vector and the comparison against r_in.
   always_comb begin
      expected = idx_q[2] ? ~(idx_q[1] | idx_q[0]) : (idx_q[1] | idx_q[0]);
      mismatch = (r_in != expected);
   end

   // Next-state and result update: settle each vector, sample once, advance.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fail_d  = fail_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               idx_d   = 3'd0;
               cnt_d   = CNT_INIT;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               fail_d  = 8'h00;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_SAMPLE: begin
            if (mismatch) begin
               fail_d[idx_q] = 1'b1;
               if (err_q != ERR_MAX) begin
                  err_d = err_q + 1'b1;
               end
            end
            if (idx_q == 3'd7) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               idx_d   = idx_q + 3'd1;
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; an asynchronous reset aborts any run and clears all results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fail_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
      end
   end

endmodule

// File: tb/tb_or_nor_checker.sv
// tb/tb_or_nor_checker.sv - directed scoreboard bench for or_nor_checker
module tb_or_nor_checker;

   // unit 0: defaults, unit 1: ERR_W=3, unit 2: SETTLE=3
   logic       clk;
   logic       rst_n  [3];
   logic       start  [3];
   logic [1:0] mode   [3];   // 0 correct gate, 1 stuck at 0, 2 inverted gate
   logic       r_in   [3];
   logic       x_o    [3];
   logic       y_o    [3];
   logic       k_o    [3];
   logic       busy_o [3];
   logic       done_o [3];
   logic       pass_o [3];
   logic [7:0] fv_o   [3];
   logic [3:0] ec0;
   logic [2:0] ec1;
   logic [3:0] ec2;

   typedef struct {
      int         lat;
      logic [7:0] fv;
      logic [3:0] ec;
      logic       ps;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   e0 = 0;
   int   n_checks = 0;
   int   n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar u = 0; u < 3; u++) begin : g_gate
      assign r_in[u] = (mode[u] == 2'd1) ? 1'b0 :
                       ((k_o[u] ? ~(x_o[u] | y_o[u]) : (x_o[u] | y_o[u])) ^ (mode[u] == 2'd2));
   end

   or_nor_checker #(.SETTLE(1), .ERR_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .r_in(r_in[0]),
      .x_out(x_o[0]), .y_out(y_o[0]), .key_out(k_o[0]), .busy(busy_o[0]),
      .done(done_o[0]), .pass(pass_o[0]), .err_count(ec0), .fail_vec(fv_o[0]));

   or_nor_checker #(.SETTLE(1), .ERR_W(3)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .r_in(r_in[1]),
      .x_out(x_o[1]), .y_out(y_o[1]), .key_out(k_o[1]), .busy(busy_o[1]),
      .done(done_o[1]), .pass(pass_o[1]), .err_count(ec1), .fail_vec(fv_o[1]));

   or_nor_checker #(.SETTLE(3), .ERR_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .r_in(r_in[2]),
      .x_out(x_o[2]), .y_out(y_o[2]), .key_out(k_o[2]), .busy(busy_o[2]),
      .done(done_o[2]), .pass(pass_o[2]), .err_count(ec2), .fail_vec(fv_o[2]));

   function automatic logic [3:0] get_ec(input int u);
      case (u)
         0:       return ec0;
         1:       return {1'b0, ec1};
         default: return ec2;
      endcase
   endfunction

   function automatic logic [2:0] get_vec(input int u);
      return {k_o[u], x_o[u], y_o[u]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard model: derive the expected result of a full run from the gate mode.
   task automatic push_exp(input int u);
      exp_t e;
      int   settle;
      int   ew;
      int   nbad;
      logic g;
      logic r;
      logic [2:0] v;
      settle = (u == 2) ? 3 : 1;
      ew     = (u == 1) ? 3 : 4;
      nbad   = 0;
      e.fv   = 8'h00;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         g = v[2] ? ~(v[1] | v[0]) : (v[1] | v[0]);
         r = (mode[u] == 2'd0) ? g : (mode[u] == 2'd1) ? 1'b0 : ~g;
         if (r != g) begin
            e.fv[i] = 1'b1;
            nbad++;
         end
      end
      e.ec  = 4'((nbad > (1 << ew) - 1) ? (1 << ew) - 1 : nbad);
      e.ps  = (nbad == 0);
      e.lat = 8 * (settle + 1);
      sb.push_back(e);
   endtask

   task automatic start_run(input int u);
      @(negedge clk);
      start[u] = 1'b1;
      @(negedge clk);
      e0 = cyc;
      start[u] = 1'b0;
   endtask

   task automatic wait_done(input int u, input string tag);
      exp_t e;
      int   lat;
      while (done_o[u] !== 1'b1 && (cyc - e0) < 100) @(negedge clk);
      lat = cyc - e0;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_fail_vec"}, fv_o[u], e.fv);
      chk({tag, "_err_count"}, get_ec(u), e.ec);
      chk({tag, "_pass"}, pass_o[u], e.ps);
      chk({tag, "_busy"}, busy_o[u], 1'b0);
      chk({tag, "_vec_hold"}, get_vec(u), 3'b111);
   endtask

   initial begin
      for (int u = 0; u < 3; u++) begin
         rst_n[u] = 1'b0;
         start[u] = 1'b0;
         mode[u]  = 2'd0;
      end
      repeat (2) @(negedge clk);
      chk("rst_busy", busy_o[0], 1'b0);
      chk("rst_done", done_o[0], 1'b0);
      chk("rst_pass", pass_o[0], 1'b0);
      chk("rst_err", get_ec(0), 4'd0);
      chk("rst_fail", fv_o[0], 8'h00);
      chk("rst_vec", get_vec(0), 3'b000);
      for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;

      // 1: correct gate
      mode[0] = 2'd0;
      push_exp(0);
      start_run(0);
      chk("t1_busy_e0", busy_o[0], 1'b1);
      chk("t1_vec_e0", get_vec(0), 3'b000);
      wait_done(0, "t1");

      // 2: stuck-at-0 gate
      mode[0] = 2'd1;
      push_exp(0);
      start_run(0);
      chk("t2_pass_low_while_running", pass_o[0], 1'b0);
      wait_done(0, "t2");

      // 3: inverted gate, 3-bit saturating counter
      mode[1] = 2'd2;
      push_exp(1);
      start_run(1);
      wait_done(1, "t3");

      // 4: start pulse mid-run is ignored
      mode[0] = 2'd1;
      push_exp(0);
      start_run(0);
      repeat (4) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      chk("t4_busy_after_ignored_start", busy_o[0], 1'b1);
      wait_done(0, "t4a");
      // start from DONE clears results and reruns
      mode[0] = 2'd0;
      push_exp(0);
      start_run(0);
      chk("t4_done_cleared", done_o[0], 1'b0);
      chk("t4_err_cleared", get_ec(0), 4'd0);
      chk("t4_fail_cleared", fv_o[0], 8'h00);
      wait_done(0, "t4b");

      // 5: asynchronous reset with idx=3
      start_run(0);
      repeat (6) @(negedge clk);
      chk("t5_vec_idx3", get_vec(0), 3'b011);
      #2 rst_n[0] = 1'b0;
      #1;
      chk("t5_rst_busy", busy_o[0], 1'b0);
      chk("t5_rst_vec", get_vec(0), 3'b000);
      chk("t5_rst_done", done_o[0], 1'b0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      push_exp(0);
      start_run(0);
      wait_done(0, "t5");

      // 6: SETTLE=3 holds each vector longer
      mode[2] = 2'd0;
      push_exp(2);
      start_run(2);
      repeat (3) @(negedge clk);
      chk("t6_vec0_held", get_vec(2), 3'b000);
      @(negedge clk);
      chk("t6_vec1_driven", get_vec(2), 3'b001);
      wait_done(2, "t6");

      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
